i2s_audio_tx: RTL and testbench
===============================

# i2s_audio_tx

Serial audio transmitter clocked by the 24.576 MHz audio PLL output. Accepts one stereo sample per frame over a valid/ready handshake and serialises it as Philips I2S with MCLK = 256·fs, BCLK = 64·fs, fs = 48 kHz. Sits directly downstream of the audio PLL and gates itself on the PLL lock flag. It feeds the board DAC/HDMI audio pins.

## Interface
- `DW`, 16: sample width, 1..32, signed two's complement.
- `BCLK_DIV`, 8: clk cycles per BCLK period; even, ≥4.
- `SLOT_W`, 32: BCLK periods per channel slot; must be > `DW`.
- `clk` in 1: audio clock, 24.576 MHz PLL output.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock flag, asynchronous to `clk`.
- `s_valid` in 1: sample pair valid.
- `s_ready` out 1: buffer can accept a pair.
- `s_left` in DW: left sample.
- `s_right` in DW: right sample.
- `i2s_mclk` out 1: clk/2.
- `i2s_bclk` out 1: bit clock.
- `i2s_lrck` out 1: word select; 0 = left, 1 = right.
- `i2s_sdata` out 1: serial data, MSB first.
- `underrun` out 1: one-cycle pulse on a frame load with an empty buffer.
- `underrun_cnt` out 8: saturating underrun count.

## Operation
- `pll_locked` passes through a 2-FF synchroniser to give `lk`. While `lk`=0:
  - the frame counter is held at 0;
  - the buffer is flushed;
  - `s_ready`, `i2s_mclk`, `i2s_bclk`, `i2s_lrck` and `i2s_sdata` are held at 0.
- Frame phase `p` runs 0..F-1, where F = 2·`SLOT_W`·`BCLK_DIV` (512 by default).
  - `p` starts at 0 on the first cycle with `lk`=1 and wraps to 0 after F-1.
- Output functions of `p` (registered values seen on cycle `p`):
  - `i2s_bclk` = (`p` mod `BCLK_DIV`) ≥ `BCLK_DIV`/2.
  - `i2s_lrck` = (`p` ≥ F/2).
  - `i2s_mclk` = `p`[0].
- Bit index `k` = (`p`/`BCLK_DIV`) mod `SLOT_W`.
  - `i2s_sdata` = bit (`DW`−`k`) of the active channel's shift sample for 1 ≤ `k` ≤ `DW`.
  - `i2s_sdata` = 0 for `k`=0 and for `k` > `DW`. This gives the standard one-BCLK I2S delay.
  - Data changes only on BCLK falling edges.
- Input buffer: one entry, `full` flag.
  - `s_ready` = `lk` & !`full`.
  - Accept (`s_valid`&`s_ready`) captures `s_left`/`s_right` and sets `full`.
- Frame load happens at `p` = F-1 and uses the pre-cycle value of `full`.
  - If `full`: copy the buffer into the shift registers and clear `full`.
  - If empty: load zeros (mute), pulse `underrun`, and increment `underrun_cnt` (saturates at 255).
  - An accept on the load cycle into an empty buffer counts as underrun; that sample plays in the following frame.
- `underrun_cnt` is cleared only by `rst_n`. Loss of lock does not clear it.
- Loss of lock mid-frame aborts the frame. On relock, output restarts at `p`=0 with zero shift registers.

## Timing
- Reset value of every output is 0. `rst_n` low forces all outputs to 0 immediately (asynchronous).
- `pll_locked` rise to first `p`=0 cycle: 2 or 3 clk. Fall to outputs forced to 0: the same latency.
- A sample accepted in frame N is heard in frame N+1. Its left MSB appears at `p` = `BCLK_DIV` of frame N+1.
- Sustained throughput: one pair per F clk. `s_ready` falls the cycle after an accept and rises the cycle after a load.

## Structure
- Shared package `audio_pkg` holds:
  - default constants `AUDIO_DW`=16, `AUDIO_BCLK_DIV`=8, `AUDIO_SLOT_W`=32;
  - derived `AUDIO_FRAME_CLKS`;
  - typedef `audio_pair_t` {left, right}.
- One sub-module, `audio_lock_sync`: a 2-FF synchroniser with asynchronous active-low reset, used for `pll_locked`.
- The counter, buffer and serialiser stay in the top module.

## Test plan
- Reset release with `pll_locked`=1 and no samples:
  - BCLK period 8 clk, `i2s_lrck` period 512 clk, `i2s_mclk` period 2 clk;
  - `i2s_sdata` always 0;
  - `underrun` pulses at every `p`=511 and `underrun_cnt` counts 1, 2, 3.
- Push L=16'h8001, R=16'h7FFE during frame 0. In frame 1:
  - left `k`=1 → 1, `k`=2..15 → 0, `k`=16 → 1;
  - right `k`=1 → 0, `k`=2..15 → 1, `k`=16 → 0;
  - `k`=0 and `k`=17..31 → 0 in both channels.
- Back-pressure: hold `s_valid`=1 with new data continuously.
  - Exactly one accept per 512 clk.
  - `s_ready` rises the cycle after `p`=511.
  - No underrun after the first frame.
- Accept into an empty buffer exactly at `p`=511:
  - `underrun` pulses;
  - the sample is output in the next frame, not the current one.
- Drop `pll_locked` at `p`=300 with the buffer full:
  - within 3 clk all outputs are 0 and `s_ready`=0;
  - after relock the first frame is zeros and `underrun_cnt` is preserved.
- Run 300 empty frames:
  - `underrun_cnt` saturates at 255;
  - asserting `rst_n`=0 mid-frame zeroes all outputs and the count asynchronously.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio constants and the stereo sample pair type.
// Pair fields are sized for the widest supported sample so any DW fits.
package audio_pkg;

   localparam int unsigned AUDIO_DW         = 16;
   localparam int unsigned AUDIO_BCLK_DIV   = 8;
   localparam int unsigned AUDIO_SLOT_W     = 32;
   localparam int unsigned AUDIO_FRAME_CLKS = 2 * AUDIO_SLOT_W * AUDIO_BCLK_DIV;
   localparam int unsigned AUDIO_MAX_DW     = 32;

   typedef struct packed {
      logic [AUDIO_MAX_DW-1:0] left;
      logic [AUDIO_MAX_DW-1:0] right;
   } audio_pair_t;

   function automatic int unsigned frame_clks(input int unsigned slot_w,
                                              input int unsigned bclk_div);
      return 2 * slot_w * bclk_div;
   endfunction

endpackage

// File: rtl/audio_lock_sync.sv
// Two-flop synchroniser for the asynchronous PLL lock flag.
module audio_lock_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic [1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[0], i_async};
      end
   end

   assign o_sync = r_sync[1];

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips I2S transmitter: one-entry sample buffer, frame phase counter and serialiser.
// All serial outputs are registered from the next-cycle phase so they line up with p.
module i2s_audio_tx
   import audio_pkg::*;
#(
   parameter int unsigned DW       = AUDIO_DW,
   parameter int unsigned BCLK_DIV = AUDIO_BCLK_DIV,
   parameter int unsigned SLOT_W   = AUDIO_SLOT_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pll_locked,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_left,
   input  logic [DW-1:0] s_right,
   output logic          i2s_mclk,
   output logic          i2s_bclk,
   output logic          i2s_lrck,
   output logic          i2s_sdata,
   output logic          underrun,
   output logic [7:0]    underrun_cnt
);

   localparam int unsigned   F      = frame_clks(SLOT_W, BCLK_DIV);
   localparam int unsigned   CW     = $clog2(F);
   localparam logic [CW-1:0] P_LAST = CW'(F - 1);

   logic                    w_lk_sync;
   logic                    r_lk;
   logic [CW-1:0]           r_cnt;
   logic [CW-1:0]           w_cnt_d;
   logic                    w_load;
   logic                    w_accept;
   logic                    w_underrun;
   logic                    r_full;
   audio_pair_t             r_buf;
   audio_pair_t             r_shift;
   logic [7:0]              r_ur_cnt;
   logic                    r_mclk;
   logic                    r_bclk;
   logic                    r_lrck;
   logic                    r_sdata;
   logic                    w_mclk_d;
   logic                    w_bclk_d;
   logic                    w_lrck_d;
   logic                    w_sdata_d;
   int unsigned             w_p_nxt;
   int unsigned             w_k_nxt;
   logic [4:0]              w_bit_idx;
   logic [AUDIO_MAX_DW-1:0] w_chan;

   audio_lock_sync u_lock_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (pll_locked),
      .o_sync  (w_lk_sync)
   );

   // r_lk is the lock flag the frame logic runs on; w_lk_sync is its next value.
   always_comb begin
      w_cnt_d = '0;
      if (w_lk_sync && r_lk) begin
         w_cnt_d = (r_cnt == P_LAST) ? '0 : r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lk  <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_lk  <= w_lk_sync;
         r_cnt <= w_cnt_d;
      end
   end

   assign s_ready    = r_lk && !r_full;
   assign w_accept   = s_valid && s_ready;
   assign w_load     = r_lk && (r_cnt == P_LAST);
   assign w_underrun = w_load && !r_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 1'b0;
         r_buf  <= '0;
      end else if (!r_lk) begin
         r_full <= 1'b0;
      end else if (w_load && r_full) begin
         r_full <= 1'b0;
      end else if (w_accept) begin
         r_full     <= 1'b1;
         r_buf.left  <= AUDIO_MAX_DW'(s_left);
         r_buf.right <= AUDIO_MAX_DW'(s_right);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
      end else if (!r_lk) begin
         r_shift <= '0;
      end else if (w_load) begin
         r_shift <= r_full ? r_buf : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ur_cnt <= '0;
      end else if (w_underrun && (r_ur_cnt != 8'hFF)) begin
         r_ur_cnt <= r_ur_cnt + 8'd1;
      end
   end

   // Slot bit 0 is the one-BCLK I2S delay; bits beyond DW pad with zeros.
   always_comb begin
      w_p_nxt   = 32'(w_cnt_d);
      w_k_nxt   = (w_p_nxt / BCLK_DIV) % SLOT_W;
      w_mclk_d  = w_lk_sync && w_cnt_d[0];
      w_bclk_d  = w_lk_sync && ((w_p_nxt % BCLK_DIV) >= (BCLK_DIV / 2));
      w_lrck_d  = w_lk_sync && (w_p_nxt >= (F / 2));
      w_chan    = w_lrck_d ? r_shift.right : r_shift.left;
      w_bit_idx = 5'(DW - w_k_nxt);
      w_sdata_d = w_lk_sync && (w_k_nxt >= 1) && (w_k_nxt <= DW) && w_chan[w_bit_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mclk  <= 1'b0;
         r_bclk  <= 1'b0;
         r_lrck  <= 1'b0;
         r_sdata <= 1'b0;
      end else begin
         r_mclk  <= w_mclk_d;
         r_bclk  <= w_bclk_d;
         r_lrck  <= w_lrck_d;
         r_sdata <= w_sdata_d;
      end
   end

   assign i2s_mclk     = r_mclk;
   assign i2s_bclk     = r_bclk;
   assign i2s_lrck     = r_lrck;
   assign i2s_sdata    = r_sdata;
   assign underrun     = w_underrun;
   assign underrun_cnt = r_ur_cnt;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Scoreboard bench for i2s_audio_tx: expected frames are queued at each modelled load
// and compared bit by bit while the following frame plays.
module tb_i2s_audio_tx;

   localparam int DW = 16;
   localparam int BD = 8;
   localparam int SW = 32;
   localparam int F  = 2 * SW * BD;
   localparam int FS = 2 * 17 * 4;

   typedef struct packed {
      logic [15:0] l;
      logic [15:0] r;
   } pair_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rst_sat_n;
   logic        pll_locked;
   logic        s_valid;
   logic [15:0] s_left;
   logic [15:0] s_right;
   logic        s_ready;
   logic        i2s_mclk;
   logic        i2s_bclk;
   logic        i2s_lrck;
   logic        i2s_sdata;
   logic        underrun;
   logic [7:0]  underrun_cnt;
   logic        sat_ready;
   logic        sat_mclk;
   logic        sat_bclk;
   logic        sat_lrck;
   logic        sat_sdata;
   logic        sat_ur;
   logic [7:0]  sat_cnt;

   int    checks   = 0;
   int    failures = 0;
   int    p        = 0;
   bit    aligned  = 1'b0;
   bit    m_full   = 1'b0;
   bit    b2b      = 1'b0;
   logic [15:0] m_l, m_r;
   pair_t cur      = '0;
   int    m_cnt    = 0;
   int    dut_acc  = 0;
   pair_t exp_q[$];

   always #5 clk = ~clk;

   i2s_audio_tx #(.DW(16), .BCLK_DIV(8), .SLOT_W(32)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pll_locked   (pll_locked),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_left       (s_left),
      .s_right      (s_right),
      .i2s_mclk     (i2s_mclk),
      .i2s_bclk     (i2s_bclk),
      .i2s_lrck     (i2s_lrck),
      .i2s_sdata    (i2s_sdata),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   // Short-frame instance so saturation is reachable in a modest cycle count.
   i2s_audio_tx #(.DW(16), .BCLK_DIV(4), .SLOT_W(17)) u_sat (
      .clk          (clk),
      .rst_n        (rst_sat_n),
      .pll_locked   (pll_locked),
      .s_valid      (1'b0),
      .s_ready      (sat_ready),
      .s_left       (16'h0),
      .s_right      (16'h0),
      .i2s_mclk     (sat_mclk),
      .i2s_bclk     (sat_bclk),
      .i2s_lrck     (sat_lrck),
      .i2s_sdata    (sat_sdata),
      .underrun     (sat_ur),
      .underrun_cnt (sat_cnt)
   );

   function automatic logic exp_bit(input int pp);
      int          k;
      logic [15:0] s;
      k = (pp / BD) % SW;
      s = (pp >= F / 2) ? cur.r : cur.l;
      if (k >= 1 && k <= DW) return s[DW-k];
      return 1'b0;
   endfunction

   // Advance one clock, updating the buffer model with the pre-edge state.
   task automatic tick();
      bit    acc;
      pair_t tmp;
      acc = aligned && s_valid && !m_full;
      if (s_valid && s_ready) dut_acc++;
      if (aligned && p == F - 1) begin
         if (m_full) begin
            tmp.l = m_l;
            tmp.r = m_r;
            m_full = 1'b0;
         end else begin
            tmp = '0;
            if (m_cnt < 255) m_cnt++;
         end
         exp_q.push_back(tmp);
      end
      if (acc) begin
         m_full = 1'b1;
         m_l    = s_left;
         m_r    = s_right;
      end
      @(posedge clk);
      #1;
      if (aligned) begin
         p = (p == F - 1) ? 0 : p + 1;
         if (p == 0 && exp_q.size() > 0) cur = exp_q.pop_front();
      end
      if (acc && b2b) begin
         s_left  = s_left + 16'd1;
         s_right = s_right - 16'd1;
      end else if (acc) begin
         s_valid = 1'b0;
      end
   endtask

   task automatic run_cycles(input int n, input string tag);
      logic [5:0] exp_v;
      logic [5:0] got_v;
      for (int i = 0; i < n; i++) begin
         exp_v = '0;
         if (aligned) begin
            exp_v[5] = ((p % BD) >= BD / 2);
            exp_v[4] = (p >= F / 2);
            exp_v[3] = p[0];
            exp_v[2] = exp_bit(p);
            exp_v[1] = (p == F - 1) && !m_full;
            exp_v[0] = !m_full;
         end
         got_v = {i2s_bclk, i2s_lrck, i2s_mclk, i2s_sdata, underrun, s_ready};
         checks++;
         if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s p=%0d {bclk,lrck,mclk,sdata,underrun,ready} got %b want %b",
                     tag, p, got_v, exp_v);
         end
         if (aligned && p == 0) begin
            checks++;
            if (underrun_cnt !== 8'(m_cnt)) begin
               failures++;
               $display("FAIL %s_cnt p=0 underrun_cnt got %0d want %0d", tag, underrun_cnt, m_cnt);
            end
         end
         tick();
      end
   endtask

   task automatic run_to(input int target, input string tag);
      run_cycles((target - p + F) % F, tag);
   endtask

   task automatic align(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (i2s_mclk !== 1'b1 && n < 12);
      checks++;
      if (i2s_mclk !== 1'b1 || n < 3 || n > 4) begin
         failures++;
         $display("FAIL %s_latency edges to p=1 got %0d want 3..4", tag, n);
      end
      p       = 1;
      aligned = 1'b1;
      m_full  = 1'b0;
      cur     = '0;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      rst_sat_n  = 1'b0;
      pll_locked = 1'b1;
      s_valid    = 1'b0;
      s_left     = '0;
      s_right    = '0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({s_ready, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdata, underrun} !== 6'b0) begin
         failures++;
         $display("FAIL reset_outputs got %b want 000000",
                  {s_ready, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdata, underrun});
      end
      checks++;
      if (underrun_cnt !== 8'd0) begin
         failures++;
         $display("FAIL reset_cnt got %0d want 0", underrun_cnt);
      end
      rst_n = 1'b1;
      align("reset");
   endtask

   task automatic test_idle();
      run_to(0, "idle");
      run_cycles(2 * F + 1, "idle");
      checks++;
      if (underrun_cnt !== 8'd3) begin
         failures++;
         $display("FAIL idle_three_underruns got %0d want 3", underrun_cnt);
      end
   endtask

   task automatic test_pattern();
      int   pts[10]  = '{4, 12, 20, 132, 140, 260, 268, 276, 388, 396};
      logic expv[10] = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 0};
      s_left  = 16'h8001;
      s_right = 16'h7FFE;
      s_valid = 1'b1;
      run_to(0, "pattern");
      for (int i = 0; i < 10; i++) begin
         run_to(pts[i], "pattern");
         checks++;
         if (i2s_sdata !== expv[i]) begin
            failures++;
            $display("FAIL pattern_bit p=%0d sdata got %b want %b", p, i2s_sdata, expv[i]);
         end
      end
      run_to(0, "pattern");
   endtask

   task automatic test_back_to_back();
      int a0;
      int c0;
      a0      = dut_acc;
      c0      = m_cnt;
      b2b     = 1'b1;
      s_left  = 16'h1000;
      s_right = 16'hF000;
      s_valid = 1'b1;
      run_cycles(4 * F, "b2b");
      s_valid = 1'b0;
      b2b     = 1'b0;
      checks++;
      if (dut_acc - a0 !== 4) begin
         failures++;
         $display("FAIL b2b_accepts got %0d want 4", dut_acc - a0);
      end
      checks++;
      if (underrun_cnt !== 8'(c0)) begin
         failures++;
         $display("FAIL b2b_no_underrun cnt got %0d want %0d", underrun_cnt, c0);
      end
   endtask

   task automatic test_load_edge();
      run_to(F - 1, "edge");
      s_left  = 16'hA5A5;
      s_right = 16'h5A5A;
      s_valid = 1'b1;
      checks++;
      if (underrun !== 1'b1) begin
         failures++;
         $display("FAIL edge_underrun got %b want 1", underrun);
      end
      run_to(12, "edge");
      checks++;
      if (i2s_sdata !== 1'b0) begin
         failures++;
         $display("FAIL edge_not_current sdata got %b want 0", i2s_sdata);
      end
      run_to(0, "edge");
      run_to(12, "edge");
      checks++;
      if (i2s_sdata !== 1'b1) begin
         failures++;
         $display("FAIL edge_next_frame sdata got %b want 1", i2s_sdata);
      end
      run_to(0, "edge");
   endtask

   task automatic test_lock_loss();
      s_left  = 16'h1234;
      s_right = 16'h4321;
      s_valid = 1'b1;
      run_to(300, "lock");
      checks++;
      if (s_ready !== 1'b0) begin
         failures++;
         $display("FAIL lock_buffer_full ready got %b want 0", s_ready);
      end
      pll_locked = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({s_ready, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdata, underrun} !== 6'b0) begin
         failures++;
         $display("FAIL lock_drop_outputs got %b want 000000",
                  {s_ready, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdata, underrun});
      end
      checks++;
      if (underrun_cnt !== 8'(m_cnt)) begin
         failures++;
         $display("FAIL lock_drop_cnt got %0d want %0d", underrun_cnt, m_cnt);
      end
      aligned = 1'b0;
      m_full  = 1'b0;
      exp_q.delete();
      repeat (5) @(posedge clk);
      #1;
      pll_locked = 1'b1;
      align("relock");
      run_to(0, "relock");
      checks++;
      if (underrun_cnt !== 8'(m_cnt)) begin
         failures++;
         $display("FAIL relock_cnt got %0d want %0d", underrun_cnt, m_cnt);
      end
   endtask

   task automatic test_saturation();
      rst_sat_n = 1'b1;
      run_cycles(1423, "sat");
      checks++;
      if (sat_cnt !== 8'd10) begin
         failures++;
         $display("FAIL sat_count_10 got %0d want 10", sat_cnt);
      end
      run_cycles(300 * FS, "sat");
      checks++;
      if (sat_cnt !== 8'd255) begin
         failures++;
         $display("FAIL sat_count_255 got %0d want 255", sat_cnt);
      end
   endtask

   task automatic test_async_reset();
      run_to(300, "areset");
      rst_n     = 1'b0;
      rst_sat_n = 1'b0;
      #2;
      checks++;
      if ({s_ready, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdata, underrun} !== 6'b0) begin
         failures++;
         $display("FAIL areset_outputs got %b want 000000",
                  {s_ready, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdata, underrun});
      end
      checks++;
      if (underrun_cnt !== 8'd0 || sat_cnt !== 8'd0) begin
         failures++;
         $display("FAIL areset_cnt got %0d/%0d want 0/0", underrun_cnt, sat_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_pattern();
      test_back_to_back();
      test_load_edge();
      test_lock_loss();
      test_saturation();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
